pipelined_shifter: RTL
======================

Name: pipelined_shifter

Overview:
- Parametrised, two-stage pipelined barrel shifter; next generation of the single-cycle 16-bit SLL/SRA/ROR shifter.
- Adds SRL and ROL, a shift amount that can reach or exceed WIDTH, carry/zero/error flags, and valid/ready handshaking on both sides.
- Sits between the decode/register-read stage and the writeback mux of the datapath, so it can be used for multi-cycle ALU issue.

Parameters:
- WIDTH, 16: data width. Must be a power of two, at least 4.
- SHW, $clog2(WIDTH)+1: shift-amount width (derived). Allows amounts 0..2*WIDTH-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/command valid.
- in_ready  out  1  stage 1 can accept this cycle.
- rs  in  WIDTH  source operand.
- shamt  in  SHW  shift amount, unsigned.
- mode  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101..111 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- rd  out  WIDTH  result.
- carry  out  1  last bit shifted or rotated out.
- zero  out  1  rd equals 0.
- err  out  1  reserved mode was used.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Both stage valid bits clear; out_valid=0.
  - rd, carry, zero, err = 0.
  - Stage data registers clear to 0.
  - Takes effect immediately, including mid-operation; in-flight ops are discarded, never emitted.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - Define s1_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s1_adv. This is combinational from out_ready; no skid buffer.
  - Stage 2 (out_valid) holds rd/carry/zero/err stable while out_valid && !out_ready.
  - Full throughput: with both ready signals held high, one result per cycle.
  - Latency: input accepted in cycle N → out_valid in cycle N+2.
  - Simultaneous output pop and input push while full is legal; no bubble.
- Stage 1:
  - Registers the mode, the sign bit, and the original rs.
  - Applies the low half of the log shifter (amount bits [SHW/2-1:0], rounded down).
  - Records whether shamt >= WIDTH.
- Stage 2:
  - Applies the remaining amount bits below bit SHW-1.
  - Computes the flags and registers the outputs.
- Arithmetic rules. Let amt = shamt, and r = amt mod WIDTH for rotates.
  - SLL: rd = rs<<amt; 0 if amt>=WIDTH. carry = rs[WIDTH-amt] for 1<=amt<=WIDTH, else 0.
  - SRL: rd = rs>>amt, zero-fill; 0 if amt>=WIDTH. carry = rs[amt-1] for 1<=amt<=WIDTH, else 0.
  - SRA: rd = rs>>>amt, sign-fill; all sign bits if amt>=WIDTH. carry = rs[amt-1] for 1<=amt<=WIDTH, rs[WIDTH-1] for amt>WIDTH, 0 for amt=0.
  - ROR: rotate right by r. carry = rd[WIDTH-1] if r!=0, else 0.
  - ROL: rotate left by r. carry = rd[0] if r!=0, else 0.
  - Reserved modes: rd = rs, carry = 0, err = 1. The op still flows through the pipeline with normal latency.
  - zero = (rd == 0) for every mode.
- Inputs are sampled only on a transfer. Values presented while !in_ready are ignored.

Test Plan:
- WIDTH=16, out_ready=1; ops SRA rs=0x800F amt=4, then ROR rs=0x1234 amt=4, on consecutive cycles → rd=0xF800 carry=1 then rd=0x4123 carry=0; out_valid exactly 2 cycles after each accept, back-to-back.
- Boundary amounts: SLL 0x0001 amt=16 → rd=0x0000 carry=1 zero=1. SRL 0x8000 amt=17 → rd=0 carry=0. SRA 0x8000 amt=31 → rd=0xFFFF carry=1. ROL 0x8001 amt=17 → rd=0x0003 carry=1.
- amt=0 in all five modes, rs=0xA5A5 → rd=0xA5A5, carry=0, zero=0, err=0.
- Reserved mode 3'b111, rs=0x1357 → rd=0x1357, err=1, carry=0.
- Backpressure: stream 4 ops with out_ready low for 3 cycles → in_ready drops after 2 accepts; outputs stay stable; all 4 results emerge in order, none lost or duplicated.
- Reset: assert rst_n low mid-stream with both stages valid → out_valid and all outputs 0 immediately (asynchronous); no stale result after release; in_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/pipelined_shifter.sv
// Two-stage pipelined barrel shifter: SLL/SRL/SRA/ROR/ROL with carry/zero/err flags
// and valid/ready handshaking on both sides (no skid buffer).
module pipelined_shifter #(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] rs,
   input  logic [SHW-1:0]   shamt,
   input  logic [2:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rd,
   output logic             carry,
   output logic             zero,
   output logic             err
);

   // LO amount bits are resolved in stage 1; bits [RW-1:LO] in stage 2; bit RW flags amt >= WIDTH.
   localparam int LO = SHW / 2;
   localparam int RW = SHW - 1;

   localparam logic [2:0] MODE_SLL = 3'b000;
   localparam logic [2:0] MODE_SRL = 3'b001;
   localparam logic [2:0] MODE_SRA = 3'b010;
   localparam logic [2:0] MODE_ROR = 3'b011;
   localparam logic [2:0] MODE_ROL = 3'b100;

   if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("pipelined_shifter: WIDTH must be a power of two and at least 4");
   end

   // Partial shift by n < WIDTH; reserved modes pass data through untouched.
   function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] x,
                                                 input logic [2:0]       m,
                                                 input logic [RW-1:0]    n);
      logic [2*WIDTH-1:0] dbl;
      logic [WIDTH-1:0]   res;
      res = x;
      dbl = {x, x};
      case (m)
         MODE_SLL: res = x << n;
         MODE_SRL: res = x >> n;
         MODE_SRA: res = WIDTH'($signed(x) >>> n);
         MODE_ROR: begin
            dbl = dbl >> n;
            res = dbl[WIDTH-1:0];
         end
         MODE_ROL: begin
            dbl = dbl << n;
            res = dbl[2*WIDTH-1:WIDTH];
         end
         default: res = x;
      endcase
      return res;
   endfunction

   // Handshake
   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s1_adv;
   logic in_fire;

   assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s1_adv;
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   // Stage 1
   logic [2:0]       s1_mode_q;
   logic             s1_sign_q;
   logic [WIDTH-1:0] s1_rs_q;
   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic [SHW-1:0]   s1_amt_q;
   logic             s1_ge_q;
   logic [RW-1:0]    lo_amt;

   assign lo_amt    = {{(RW-LO){1'b0}}, shamt[LO-1:0]};
   assign s1_data_d = shift_op(rs, mode, lo_amt);

   // Stage 2
   logic [WIDTH-1:0] rd_q, rd_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic [RW-1:0]    hi_amt;
   logic [RW-1:0]    sll_idx;
   logic [RW-1:0]    sr_idx;
   logic             amt_nz;
   logic             amt_le_w;
   logic             rot_nz;

   assign hi_amt   = {s1_amt_q[RW-1:LO], {LO{1'b0}}};
   assign sll_idx  = RW'(SHW'(WIDTH) - s1_amt_q);
   assign sr_idx   = RW'(s1_amt_q - SHW'(1));
   assign amt_nz   = |s1_amt_q;
   assign amt_le_w = (s1_amt_q <= SHW'(WIDTH));
   assign rot_nz   = |s1_amt_q[RW-1:0];

   // Carry indices are taken from the original operand, valid only for 1 <= amt <= WIDTH.
   always_comb begin
      rd_d    = shift_op(s1_data_q, s1_mode_q, hi_amt);
      carry_d = 1'b0;
      err_d   = 1'b0;
      case (s1_mode_q)
         MODE_SLL: begin
            if (s1_ge_q) rd_d = '0;
            if (amt_nz && amt_le_w) carry_d = s1_rs_q[sll_idx];
         end
         MODE_SRL: begin
            if (s1_ge_q) rd_d = '0;
            if (amt_nz && amt_le_w) carry_d = s1_rs_q[sr_idx];
         end
         MODE_SRA: begin
            if (s1_ge_q) rd_d = {WIDTH{s1_sign_q}};
            if (amt_nz && amt_le_w) begin
               carry_d = s1_rs_q[sr_idx];
            end else if (amt_nz) begin
               carry_d = s1_sign_q;
            end
         end
         MODE_ROR: carry_d = rot_nz & rd_d[WIDTH-1];
         MODE_ROL: carry_d = rot_nz & rd_d[0];
         default:  err_d   = 1'b1;
      endcase
      zero_d = ~|rd_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= '0;
         s1_sign_q  <= 1'b0;
         s1_rs_q    <= '0;
         s1_data_q  <= '0;
         s1_amt_q   <= '0;
         s1_ge_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         rd_q       <= '0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (in_fire) begin
            s1_mode_q <= mode;
            s1_sign_q <= rs[WIDTH-1];
            s1_rs_q   <= rs;
            s1_data_q <= s1_data_d;
            s1_amt_q  <= shamt;
            s1_ge_q   <= shamt[SHW-1];
         end
         // Outputs only change on advance, so they hold while stalled.
         if (s1_adv) begin
            rd_q    <= rd_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign rd        = rd_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule
